load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/load_store_unit.sv | 137 +++++++++++++
 tb/tb_load_store_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and constants for the load/store unit and its lane aligner.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int unsigned MEM_DEPTH = 64;
  localparam int unsigned ADDR_HI   = 9;
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} lsu_state_e;

  // Natural alignment: an access of 2^size bytes must start on a 2^size boundary.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic m;
    case (size)
      SZ_H:    m = off[0];
      SZ_W:    m = |off[1:0];
      SZ_D:    m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: load extract/extend and sub-doubleword store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  offset,
  input  logic        is_signed,
  input  logic [63:0] dword,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] store_data
);

  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] mask;
  logic [63:0] lane_mask;

  assign shamt = {offset, 3'b000};

  always_comb begin
    shifted = dword >> shamt;
    case (size)
      SZ_B: begin
        mask      = 64'h0000_0000_0000_00ff;
        load_data = {{56{is_signed & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        mask      = 64'h0000_0000_0000_ffff;
        load_data = {{48{is_signed & shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        mask      = 64'h0000_0000_ffff_ffff;
        load_data = {{32{is_signed & shifted[31]}}, shifted[31:0]};
      end
      default: begin
        mask      = '1;
        load_data = shifted;
      end
    endcase
    lane_mask  = mask << shamt;
    store_data = (dword & ~lane_mask) | ((wdata & mask) << shamt);
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: byte-addressed load/store requests onto a doubleword-indexed
// synchronous memory, with read-modify-write for narrow stores.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_En,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        mem_memRead,
  output logic        mem_memWrite,
  input  logic [63:0] mem_read_data
);

  lsu_state_e  state_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;
  logic [2:0]  offset_q;
  logic [63:0] wdata_q;
  logic        en_q;
  logic        rd_q;
  logic        wr_q;
  logic        req_err;
  logic [63:0] load_data;
  logic [63:0] store_data;

  assign req_err = (|req_addr[63:ADDR_HI]) || misaligned(req_size, req_addr[2:0]);

  // Strobes are masked by Rst so a reset in the issue cycle itself still blocks the write.
  assign mem_En       = en_q & ~Rst;
  assign mem_memRead  = rd_q & ~Rst;
  assign mem_memWrite = wr_q & ~Rst;

  lsu_lane_align u_lane_align (
    .size      (size_q),
    .offset    (offset_q),
    .is_signed (signed_q),
    .dword     (mem_read_data),
    .wdata     (wdata_q),
    .load_data (load_data),
    .store_data(store_data)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q        <= IDLE;
      size_q         <= SZ_B;
      signed_q       <= 1'b0;
      write_q        <= 1'b0;
      offset_q       <= '0;
      wdata_q        <= '0;
      en_q           <= 1'b0;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            size_q     <= req_size;
            signed_q   <= req_signed;
            write_q    <= req_write;
            offset_q   <= req_addr[2:0];
            wdata_q    <= req_wdata;
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state_q    <= RESP;
            end else begin
              mem_address <= {{(64 - IDX_W){1'b0}}, req_addr[ADDR_HI-1:3]};
              en_q        <= 1'b1;
              if (req_write && req_size == SZ_D) begin
                wr_q           <= 1'b1;
                mem_write_data <= req_wdata;
                state_q        <= WR_ISSUE;
              end else begin
                rd_q    <= 1'b1;
                state_q <= RD_ISSUE;
              end
            end
          end
        end
        RD_ISSUE: begin
          en_q    <= 1'b0;
          rd_q    <= 1'b0;
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (write_q) begin
            mem_write_data <= store_data;
            en_q           <= 1'b1;
            wr_q           <= 1'b1;
            state_q        <= WR_ISSUE;
          end else begin
            resp_rdata <= load_data;
            resp_valid <= 1'b1;
            state_q    <= RESP;
          end
        end
        WR_ISSUE: begin
          en_q       <= 1'b0;
          wr_q       <= 1'b0;
          resp_valid <= 1'b1;
          state_q    <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random requests against a byte-level reference model and a 64x64 memory.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_En;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_memRead;
  logic        mem_memWrite;
  logic [63:0] mem_read_data;

  always #5 Clk = ~Clk;

  load_store_unit dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_En        (mem_En),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_memRead   (mem_memRead),
    .mem_memWrite  (mem_memWrite),
    .mem_read_data (mem_read_data)
  );

  // Synchronous data memory seen by the DUT, with bench-side clear/preload.
  logic [63:0] mem [64];
  logic        mem_clear = 1'b0;
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [63:0] pl_data = '0;

  always @(posedge Clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (mem_En) begin
      if (mem_memWrite) mem[mem_address[5:0]] <= mem_write_data;
      if (mem_memRead) mem_read_data <= mem[mem_address[5:0]];
    end
  end

  int   viol = 0;
  int   n_wr = 0;
  int   n_resp = 0;
  logic hi_bad = 1'b0;

  always @(posedge Clk) begin
    if ((mem_memRead && mem_memWrite) || (mem_En != (mem_memRead | mem_memWrite)))
      viol <= viol + 1;
    if (mem_En && |mem_address[63:6]) hi_bad <= 1'b1;
    if (mem_memWrite) n_wr <= n_wr + 1;
    if (resp_valid) n_resp <= n_resp + 1;
  end

  // Reference: the 512-byte address space as plain bytes.
  logic [7:0]  ref_b [512];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] last_rdata;

  function automatic logic [63:0] ref_load(input int a, input int n, input logic sg);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_b[a + i]) << (8 * i));
    if (sg && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    int          bad;
    logic [63:0] e;
    bad = 0;
    for (int d = 0; d < 64; d++) begin
      e = ref_load(d * 8, 8, 1'b0);
      if (mem[d] !== e) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [63:0] a, input logic [63:0] wd, input string tag);
    int          n;
    logic        e;
    int          exp_lat;
    logic [15:0] exp_rdm;
    logic [15:0] exp_wrm;
    logic [63:0] exp_rd;
    logic [15:0] rdm;
    logic [15:0] wrm;
    int          lat;
    int          wt;
    logic        gerr;
    logic        abad;
    logic        rdy_after;
    logic [63:0] grd;
    n       = 1 << sz;
    e       = (a[63:9] != 0) || ((a % 64'(n)) != 0);
    exp_rd  = (!w && !e) ? ref_load(int'(a[8:0]), n, sg) : 64'd0;
    exp_lat = e ? 1 : (!w ? 3 : (sz == 2'b11 ? 2 : 4));
    exp_rdm = (!e && !(w && sz == 2'b11)) ? 16'd2 : 16'd0;
    exp_wrm = (!e && w) ? (sz == 2'b11 ? 16'd2 : 16'd8) : 16'd0;
    @(negedge Clk);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    wt = 0;
    while (!req_ready && wt < 20) begin
      @(negedge Clk);
      wt++;
    end
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    rdm = '0; wrm = '0; lat = 0; gerr = 1'b0; grd = '0; abad = 1'b0; rdy_after = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_memRead) rdm[k] = 1'b1;
      if (mem_memWrite) wrm[k] = 1'b1;
      if ((mem_memRead || mem_memWrite) && mem_address !== {58'b0, a[8:3]}) abad = 1'b1;
      if (lat != 0) begin
        rdy_after = req_ready;
        break;
      end
      if (resp_valid) begin
        lat  = k;
        gerr = resp_err;
        grd  = resp_rdata;
      end
    end
    last_rdata = grd;
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_err"}, 64'(gerr), 64'(e));
    check({tag, "_rdata"}, grd, exp_rd);
    check({tag, "_rd_cycles"}, 64'(rdm), 64'(exp_rdm));
    check({tag, "_wr_cycles"}, 64'(wrm), 64'(exp_wrm));
    check({tag, "_addr"}, 64'(abad), 64'd0);
    check({tag, "_ready_after"}, 64'(rdy_after), 64'd1);
    if (w && !e)
      for (int i = 0; i < n; i++) ref_b[int'(a[8:0]) + i] = wd[8*i +: 8];
  endtask

  initial begin
    logic [63:0] r_a;
    logic [1:0]  r_sz;
    logic        r_w;
    logic        r_sg;
    logic [63:0] r_wd;
    int          n_wr0;
    int          n_resp0;
    int          acc2;
    int          r1;
    int          r2;
    logic [63:0] rd2;

    Rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    mem_clear = 1'b1;
    for (int i = 0; i < 512; i++) ref_b[i] = 8'h00;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    mem_clear = 1'b0;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_strobes", {61'b0, mem_En, mem_memRead, mem_memWrite}, 64'd0);
    check("rst_mem_address", mem_address, 64'd0);
    check("rst_mem_wdata", mem_write_data, 64'd0);

    pl_en = 1'b1; pl_idx = 6'd1; pl_data = 64'h8877_6655_4433_2211;
    @(negedge Clk);
    pl_en = 1'b0;
    for (int i = 0; i < 8; i++) ref_b[8 + i] = pl_data[8*i +: 8];

    run_req(1'b0, 2'b00, 1'b1, 64'h0F, 64'd0, "lb_0f");
    check("lb_0f_lit", last_rdata, 64'hFFFF_FFFF_FFFF_FF88);
    run_req(1'b0, 2'b10, 1'b0, 64'h0C, 64'd0, "lwu_0c");
    check("lwu_0c_lit", last_rdata, 64'h0000_0000_8877_6655);
    run_req(1'b0, 2'b01, 1'b1, 64'h0A, 64'd0, "lh_0a");
    check("lh_0a_lit", last_rdata, 64'h0000_0000_0000_4433);
    run_req(1'b1, 2'b01, 1'b0, 64'h0A, 64'hBEEF, "sh_0a");
    check("sh_0a_mem", mem[1], 64'h8877_6655_BEEF_2211);
    run_req(1'b0, 2'b10, 1'b0, 64'h0E, 64'd0, "lw_misalign");
    run_req(1'b1, 2'b11, 1'b0, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF, "sd_range");
    check_mem("mem_after_err");

    // Reset during the read-wait cycle of a byte store.
    n_wr0 = n_wr;
    n_resp0 = n_resp;
    @(negedge Clk);
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 64'h08;
    req_wdata = 64'h5A; req_valid = 1'b1;
    check("rstmid_ready", 64'(req_ready), 64'd1);
    @(negedge Clk);
    req_valid = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("rstmid_ready_after", 64'(req_ready), 64'd1);
    repeat (4) @(negedge Clk);
    check("rstmid_no_write", 64'(n_wr - n_wr0), 64'd0);
    check("rstmid_no_resp", 64'(n_resp - n_resp0), 64'd0);
    check_mem("rstmid_mem");

    // Back-to-back: double store then double load with req_valid held.
    @(negedge Clk);
    req_write = 1'b1; req_size = 2'b11; req_signed = 1'b0; req_addr = 64'h18;
    req_wdata = 64'h0123_4567_89AB_CDEF; req_valid = 1'b1;
    check("b2b_ready", 64'(req_ready), 64'd1);
    acc2 = 0; r1 = 0; r2 = 0; rd2 = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (k == 1) begin
        req_write = 1'b0;
        req_wdata = '0;
      end
      if (acc2 != 0 && k == acc2 + 1) req_valid = 1'b0;
      if (resp_valid) begin
        if (r1 == 0) r1 = k;
        else if (r2 == 0) begin
          r2  = k;
          rd2 = resp_rdata;
        end
      end
      if (acc2 == 0 && req_valid && req_ready) acc2 = k;
    end
    for (int i = 0; i < 8; i++) ref_b[8'h18 + i] = 8'(64'h0123_4567_89AB_CDEF >> (8 * i));
    check("b2b_resp1", 64'(r1), 64'd2);
    check("b2b_accept2", 64'(acc2), 64'd3);
    check("b2b_resp2", 64'(r2), 64'd6);
    check("b2b_rdata", rd2, 64'h0123_4567_89AB_CDEF);

    for (int t = 0; t < 48; t++) begin
      r_sz = 2'($urandom_range(0, 3));
      r_w  = 1'($urandom_range(0, 1));
      r_sg = 1'($urandom_range(0, 1));
      r_a  = 64'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) r_a = r_a & ~((64'd1 << r_sz) - 64'd1);
      if ($urandom_range(0, 9) == 0) r_a[$urandom_range(9, 63)] = 1'b1;
      r_wd = {$urandom, $urandom};
      run_req(r_w, r_sz, r_sg, r_a, r_wd, "rnd");
    end

    check_mem("mem_final");
    check("proto_viol", 64'(viol), 64'd0);
    check("addr_hi_bits", 64'(hi_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
